// File: rtl/conv_seq_engine.sv
// Single-MAC 2-D convolution/correlation engine: latches an image and kernel on start,
// walks every valid window one tap per cycle and streams each result over valid/ready.
module conv_seq_engine #(
  parameter int DATA_W = 8,
  parameter int IMG    = 4,
  parameter int KER    = 3,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1,
  localparam int RW    = $clog2(IMG - KER + 1) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [IMG*IMG*DATA_W-1:0]  img_i,
  input  logic [KER*KER*DATA_W-1:0]  ker_i,
  output logic                       busy_o,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [RW-1:0]              out_row,
  output logic [RW-1:0]              out_col,
  output logic                       done_o
);

  localparam int KW  = $clog2(KER) + 1;
  localparam int IIW = $clog2(IMG*IMG*DATA_W);
  localparam int KIW = (KER*KER*DATA_W > 1) ? $clog2(KER*KER*DATA_W) : 1;
  localparam logic [KW-1:0]    KLAST = KW'(KER - 1);
  localparam logic [RW-1:0]    WLAST = RW'(IMG - KER);
  localparam logic [ACC_W-1:0] UMAX  = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [ACC_W-1:0] SMAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t                      state_q;
  logic [IMG*IMG*DATA_W-1:0]   img_q;
  logic [KER*KER*DATA_W-1:0]   ker_q;
  logic                        mode_q;
  logic [ACC_W-1:0]            acc_q;
  logic [RW-1:0]               r_q, c_q;
  logic [KW-1:0]               i_q, j_q;
  logic                        fin_q;
  logic                        busy_q, valid_q, done_q;
  logic [DATA_W-1:0]           data_q;
  logic [RW-1:0]               row_q, col_q;

  int                          pix_idx_s, ker_idx_s;
  logic [IIW-1:0]              pix_base_s;
  logic [KIW-1:0]              ker_base_s;
  logic [DATA_W-1:0]           pix_s, kv_s;
  logic [2*DATA_W-1:0]         pix_ext_s, kv_ext_s, prod_s;
  logic [ACC_W-1:0]            acc_d;

  // Shift then clamp or truncate the accumulator into the output width.
  function automatic logic [DATA_W-1:0] scale_fn(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] ts;
    logic        [ACC_W-1:0] tu;
    logic        [DATA_W-1:0] res;
    ts = $signed(a) >>> SHIFT;
    tu = a >> SHIFT;
    if (SIGNED != 0) begin
      if ((SAT != 0) && (ts > $signed(SMAX)))      res = SMAX[DATA_W-1:0];
      else if ((SAT != 0) && (ts < $signed(SMIN))) res = SMIN[DATA_W-1:0];
      else                                         res = ts[DATA_W-1:0];
    end else begin
      if ((SAT != 0) && (tu > UMAX)) res = UMAX[DATA_W-1:0];
      else                           res = tu[DATA_W-1:0];
    end
    return res;
  endfunction

  // Tap operand fetch and one multiply-accumulate step.
  always_comb begin
    pix_idx_s = (int'(r_q) + int'(i_q)) * IMG + int'(c_q) + int'(j_q);
    if (mode_q) ker_idx_s = (KER - 1 - int'(i_q)) * KER + (KER - 1 - int'(j_q));
    else        ker_idx_s = int'(i_q) * KER + int'(j_q);
    pix_base_s = IIW'(pix_idx_s * DATA_W);
    ker_base_s = KIW'(ker_idx_s * DATA_W);
    pix_s = img_q[pix_base_s +: DATA_W];
    kv_s  = ker_q[ker_base_s +: DATA_W];
    // Sign-extending before an unsigned multiply gives the correct low 2*DATA_W bits.
    if (SIGNED != 0) begin
      pix_ext_s = {{DATA_W{pix_s[DATA_W-1]}}, pix_s};
      kv_ext_s  = {{DATA_W{kv_s[DATA_W-1]}}, kv_s};
    end else begin
      pix_ext_s = {{DATA_W{1'b0}}, pix_s};
      kv_ext_s  = {{DATA_W{1'b0}}, kv_s};
    end
    prod_s = pix_ext_s * kv_ext_s;
    acc_d  = acc_q + {{(ACC_W-2*DATA_W){(SIGNED != 0) & prod_s[2*DATA_W-1]}}, prod_s};
  end

  // Control FSM with window/tap counters and registered result port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      ker_q   <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            img_q   <= img_i;
            ker_q   <= ker_i;
            mode_q  <= mode_i;
            acc_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (!fin_q) begin
            acc_q <= acc_d;
            if (j_q == KLAST) begin
              j_q <= '0;
              if (i_q == KLAST) begin
                i_q   <= '0;
                fin_q <= 1'b1;
              end else begin
                i_q <= i_q + KW'(1);
              end
            end else begin
              j_q <= j_q + KW'(1);
            end
          end else begin
            fin_q   <= 1'b0;
            data_q  <= scale_fn(acc_q);
            row_q   <= r_q;
            col_q   <= c_q;
            valid_q <= 1'b1;
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            if (c_q == WLAST) begin
              c_q <= '0;
              if (r_q == WLAST) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                r_q     <= r_q + RW'(1);
                state_q <= S_MAC;
              end
            end else begin
              c_q     <= c_q + RW'(1);
              state_q <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_conv_seq_engine.sv
// Directed bench: four engine variants (unsigned sat, unsigned wrap, signed sat, signed shift-1)
// share one stimulus stream; every result is compared against hand-computed bytes.
module tb_conv_seq_engine;

  localparam int DW  = 8;
  localparam int IMG = 4;
  localparam int KER = 3;
  localparam int RW  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_i;
  logic                   mode_i;
  logic                   out_ready;
  logic [IMG*IMG*DW-1:0]  img_i;
  logic [KER*KER*DW-1:0]  ker_i;
  logic                   busy  [4];
  logic                   valid [4];
  logic                   done  [4];
  logic [DW-1:0]          data  [4];
  logic [RW-1:0]          row   [4];
  logic [RW-1:0]          col   [4];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    conv_seq_engine #(
      .DATA_W(DW), .IMG(IMG), .KER(KER), .ACC_W(20),
      .SIGNED((g >= 2) ? 1 : 0), .SHIFT((g == 3) ? 1 : 0), .SAT((g == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
      .img_i(img_i), .ker_i(ker_i), .busy_o(busy[g]),
      .out_valid(valid[g]), .out_ready(out_ready), .out_data(data[g]),
      .out_row(row[g]), .out_col(col[g]), .done_o(done[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IMG*IMG*DW-1:0] img_fill(input logic [7:0] v, input logic ramp);
    logic [IMG*IMG*DW-1:0] r;
    for (int p = 0; p < IMG*IMG; p++) r[p*DW +: DW] = ramp ? 8'(p + 1) : v;
    return r;
  endfunction

  function automatic logic [KER*KER*DW-1:0] ker_fill(input logic [7:0] v, input logic impulse);
    logic [KER*KER*DW-1:0] r;
    for (int p = 0; p < KER*KER; p++) r[p*DW +: DW] = impulse ? ((p == 0) ? 8'd1 : 8'd0) : v;
    return r;
  endfunction

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!valid[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!valid[0]) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ev[g] packs the four expected bytes of variant g, output k in bits [8k+7:8k].
  task automatic run_job(input string name, input logic mode, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input int stall_at);
    logic [31:0] ev [4];
    int cyc;
    ev = '{e0, e1, e2, e3};
    @(negedge clk);
    mode_i  = mode;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    img_i   = ~img_i;
    ker_i   = ~ker_i;
    mode_i  = ~mode;
    check({name, "_busy_start"}, 32'(busy[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(name, cyc);
      check($sformatf("%s_lat%0d", name, k), cyc, 32'd10);
      check($sformatf("%s_row%0d", name, k), 32'(row[0]), 32'(k / 2));
      check($sformatf("%s_col%0d", name, k), 32'(col[0]), 32'(k % 2));
      for (int g = 0; g < 4; g++)
        check($sformatf("%s_data%0d_v%0d", name, k, g), 32'(data[g]), 32'(ev[g][k*8 +: 8]));
      if (k == stall_at) begin
        out_ready = 1'b0;
        start_i   = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          start_i = 1'b0;
          check($sformatf("%s_stall_valid%0d", name, s), 32'(valid[0]), 32'd1);
          check($sformatf("%s_stall_data%0d", name, s), 32'(data[0]), 32'(ev[0][k*8 +: 8]));
          check($sformatf("%s_stall_rc%0d", name, s), 32'({row[0], col[0]}), 32'({2'(k / 2), 2'(k % 2)}));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      check($sformatf("%s_valid_drop%0d", name, k), 32'(valid[0]), 32'd0);
      if (k < 3) check($sformatf("%s_no_done%0d", name, k), 32'(done[0]), 32'd0);
    end
    check({name, "_done_pulse"}, 32'({done[0], busy[0]}), 32'b11);
    @(negedge clk);
    check({name, "_done_end"}, 32'({done[0], busy[0]}), 32'b00);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; out_ready = 1'b1;
    img_i = '0; ker_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy[0], valid[0], done[0], data[0], row[0], col[0]}), 32'd0);
    rst = 1'b0;

    img_i = img_fill(8'd1, 1'b0);   ker_i = ker_fill(8'd1, 1'b0);
    run_job("ones", 1'b0, 32'h09090909, 32'h09090909, 32'h09090909, 32'h04040404, -1);

    img_i = img_fill(8'd0, 1'b1);   ker_i = ker_fill(8'd0, 1'b1);
    run_job("corr", 1'b0, 32'h06050201, 32'h06050201, 32'h06050201, 32'h03020100, -1);
    img_i = img_fill(8'd0, 1'b1);   ker_i = ker_fill(8'd0, 1'b1);
    run_job("conv", 1'b1, 32'h100F0C0B, 32'h100F0C0B, 32'h100F0C0B, 32'h08070605, -1);

    img_i = img_fill(8'hFF, 1'b0);  ker_i = ker_fill(8'hFF, 1'b0);
    run_job("max", 1'b0, 32'hFFFFFFFF, 32'h09090909, 32'h09090909, 32'h04040404, -1);

    img_i = img_fill(8'hFF, 1'b0);  ker_i = ker_fill(8'd2, 1'b0);
    run_job("neg", 1'b0, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hF7F7F7F7, -1);

    img_i = img_fill(8'd0, 1'b1);   ker_i = ker_fill(8'd0, 1'b1);
    run_job("stall", 1'b0, 32'h06050201, 32'h06050201, 32'h06050201, 32'h03020100, 1);

    // Abort during the third window's MAC phase, then rerun from scratch.
    img_i = img_fill(8'd1, 1'b0);   ker_i = ker_fill(8'd1, 1'b0);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_valid("abort", cyc);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({busy[0], valid[0], done[0], data[0], row[0], col[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      saw_done = saw_done | done[0] | valid[0] | busy[0];
    end
    check("abort_quiet", 32'(saw_done), 32'd0);

    img_i = img_fill(8'd1, 1'b0);   ker_i = ker_fill(8'd1, 1'b0);
    run_job("rerun", 1'b0, 32'h09090909, 32'h09090909, 32'h09090909, 32'h04040404, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
